// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with single-cycle flush; used for the fetch buffer
// and for the queue of PCs belonging to outstanding memory requests.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    // Storage is data only; pointers define validity, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order memory requests with credit flow
// control, a flushable return buffer and redirect with stale-response dropping.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             rsp_accept;
    logic             rsp_keep;
    logic             buf_pop;
    logic             buf_empty;
    logic             buf_full;
    logic [XLEN-1:0]  redirect_target;
    logic [XLEN-1:0]  pcq_head;
    fetch_entry_t     buf_wdata;
    fetch_entry_t     buf_rdata;

    logic [1:0]       redirect_lsb_unused;
    logic [CNT_W-1:0] pcq_count_unused;
    logic             pcq_empty_unused;
    logic             pcq_full_unused;

    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = redirect_pc[1:0];

    // Credit comes from registered counts only, so a pop frees a slot next cycle.
    assign credit_used    = {1'b0, inflight} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && (inflight != '0);
    assign rsp_keep   = rsp_accept && (drop == '0) && !redirect_valid;
    assign buf_wdata  = '{pc: pcq_head, instr: imem_rsp_data};

    assign if_valid = !buf_empty;
    assign buf_pop  = if_valid && if_ready && !redirect_valid;
    assign if_instr = if_valid ? buf_rdata.instr : NOP_INSTR;
    assign if_pc    = buf_rdata.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            if (redirect_valid)
                pc <= redirect_target;
            else if (req_fire)
                pc <= pc_next(pc);

            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_accept);

            // Everything still outstanding after a redirect belongs to the old path.
            if (redirect_valid)
                drop <= inflight - CNT_W'(rsp_accept);
            else if (rsp_accept && (drop != '0))
                drop <= drop - CNT_W'(1);
        end
    end

    // Stale entries stay in the PC queue and retire with their dropped responses.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_fire),
        .wdata (pc),
        .pop   (rsp_accept),
        .rdata (pcq_head),
        .count (pcq_count_unused),
        .empty (pcq_empty_unused),
        .full  (pcq_full_unused)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fetch_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .wdata (buf_wdata),
        .pop   (buf_pop),
        .rdata (buf_rdata),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    a_rsp_needs_request: assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (inflight != '0));

    a_buf_no_overflow: assert property (
        @(posedge clk) disable iff (rst) rsp_keep |-> (!buf_full || buf_pop));

endmodule
